// File: rtl/pow_sq_mul_step.sv
// One square-and-multiply step: consumes exp[0], squares base, shifts exp right.
// Purely combinational (zero latency); no handshake, the caller decides when to register it.
module pow_sq_mul_step #(
    parameter int w  = 8,
    parameter int ew = 4
) (
    input  logic [w-1:0]  acc,
    input  logic [w-1:0]  base,
    input  logic [ew-1:0] exp,
    output logic [w-1:0]  acc_nxt,
    output logic [w-1:0]  base_nxt,
    output logic [ew-1:0] exp_nxt
);

    // Products are assigned into w-bit targets, so they wrap mod 2^w.
    always_comb begin
        acc_nxt  = exp[0] ? w'(acc * base) : acc;
        base_nxt = w'(base * base);
        exp_nxt  = exp >> 1;
    end

endmodule

// File: rtl/pow_n_multi_cycle_fsm.sv
// Computes n^e mod 2^w by square-and-multiply, one exponent bit per cycle.
// Latency bitlen(e)+1 from accept; result held in DONE until res_rdy, n_rdy only in IDLE.
module pow_n_multi_cycle_fsm #(
    parameter int w  = 8,
    parameter int ew = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          n_vld,
    output logic          n_rdy,
    input  logic [w-1:0]  n,
    input  logic [ew-1:0] e,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [w-1:0]  res
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          res_vld_q;
    logic          res_vld_d;
    logic          load;
    logic          step;
    logic          capture;

    logic [w-1:0]  acc_q;
    logic [w-1:0]  base_q;
    logic [ew-1:0] exp_q;
    logic [w-1:0]  res_q;
    logic [w-1:0]  acc_nxt;
    logic [w-1:0]  base_nxt;
    logic [ew-1:0] exp_nxt;

    pow_sq_mul_step #(
        .w  (w),
        .ew (ew)
    ) u_step (
        .acc      (acc_q),
        .base     (base_q),
        .exp      (exp_q),
        .acc_nxt  (acc_nxt),
        .base_nxt (base_nxt),
        .exp_nxt  (exp_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_vld_q <= res_vld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        res_vld_d = res_vld_q;
        load      = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (n_vld) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Exponent exhausted: acc already holds the final product.
                if (exp_q == '0) begin
                    capture   = 1'b1;
                    res_vld_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (res_rdy) begin
                    res_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                res_vld_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Datapath registers carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        if (load) begin
            base_q <= n;
            exp_q  <= e;
            acc_q  <= w'(1);
        end else if (step) begin
            base_q <= base_nxt;
            exp_q  <= exp_nxt;
            acc_q  <= acc_nxt;
        end
        if (capture) begin
            res_q <= acc_q;
        end
    end

    assign n_rdy   = (state_q == IDLE);
    assign res_vld = res_vld_q;
    assign res     = res_q;

endmodule
